// File: rtl/seq_pkg.sv
// Shared encodings and widths for the serial-stream controller.
package seq_pkg;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 5;
  localparam int IDX_W  = 4;

  localparam logic [IDX_W-1:0] NO_MATCH = 4'hF;
  localparam logic [LEN_W-1:0] MAX_LEN  = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STEP   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Requests longer than the shift register are served as full-length runs.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

endpackage

// File: rtl/seq_stream_ctrl_step_tick.sv
// step_tick: modulo-PRESCALE counter with synchronous clear and a one-cycle tick.
// Only compiled when STEP_PRESCALE_EN is defined; the default build has no prescaler.
`ifdef STEP_PRESCALE_EN
module step_tick #(
  parameter int PRESCALE = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule
`endif

// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: shifts a pattern LSB-first into an external sequence detector and tallies its hits.
// Define STEP_PRESCALE_EN to pace every STEP on a tick from step_tick (PRESCALE cycles apart).
module seq_stream_ctrl
  import seq_pkg::*;
#(
  parameter int DATA_W   = seq_pkg::DATA_W,
  parameter int PRESCALE = 4
) (
  input  logic              system_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [LEN_W-1:0]  len,
  input  logic              det_z,
  output logic              det_x,
  output logic              det_step,
  output logic              det_clr,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  match_cnt,
  output logic [IDX_W-1:0]  first_idx,
  output logic [2:0]        state_q
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_shreg;
  logic [LEN_W-1:0]  r_remain;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_first;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_x_hold;
  logic              w_tick;

`ifdef STEP_PRESCALE_EN
  logic w_tick_clr;

  // Counter restarts on LOAD and after every SAMPLE so each STEP waits a full period.
  assign w_tick_clr = (r_state == S_LOAD) || (r_state == S_SAMPLE);

  step_tick #(
    .PRESCALE (PRESCALE)
  ) u_step_tick (
    .i_clk  (system_clk),
    .i_rst  (reset),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick)
  );
`else
  // No prescaler: every STEP cycle is a tick for any legal PRESCALE.
  assign w_tick = (PRESCALE >= 1);
`endif

  always_comb begin
    w_next   = r_state;
    det_step = 1'b0;
    det_clr  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    det_x    = r_x_hold;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        busy    = 1'b1;
        det_clr = 1'b1;
        w_next  = S_STEP;
      end
      S_STEP: begin
        busy  = 1'b1;
        det_x = r_shreg[0];
        if (w_tick) begin
          det_step = 1'b1;
          w_next   = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        busy   = 1'b1;
        w_next = (r_remain > LEN_W'(1)) ? S_STEP : S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_remain <= '0;
      r_idx    <= '0;
      r_first  <= NO_MATCH;
      r_cnt    <= '0;
      r_x_hold <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start && (len == '0)) begin
            r_cnt   <= '0;
            r_first <= NO_MATCH;
          end
        end
        S_LOAD: begin
          r_shreg  <= data_in;
          r_remain <= clamp_len(len);
          r_idx    <= '0;
          r_cnt    <= '0;
          r_first  <= NO_MATCH;
        end
        S_STEP: begin
          r_x_hold <= r_shreg[0];
        end
        S_SAMPLE: begin
          // det_z is the detector's registered response to the bit stepped in the previous cycle.
          if (det_z) begin
            r_cnt <= r_cnt + LEN_W'(1);
            if (r_first == NO_MATCH) begin
              r_first <= r_idx;
            end
          end
          r_shreg  <= r_shreg >> 1;
          r_remain <= r_remain - LEN_W'(1);
          r_idx    <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign match_cnt = r_cnt;
  assign first_idx = r_first;
  assign state_q   = r_state;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Bench for seq_stream_ctrl: detector model for pattern 1,0,1,0,1,1 plus a cycle-level run scoreboard.
module tb_seq_stream_ctrl;

  localparam int DATA_W   = 16;
  localparam int PRESCALE = 4;
`ifdef STEP_PRESCALE_EN
  localparam int P   = PRESCALE + 1;
  localparam int D6  = 32;
  localparam int D12 = 62;
  localparam int D16 = 82;
`else
  localparam int P   = 2;
  localparam int D6  = 14;
  localparam int D12 = 26;
  localparam int D16 = 34;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [4:0]        len = '0;
  logic              det_z;
  logic              det_x, det_step, det_clr, busy, done;
  logic [4:0]        match_cnt;
  logic [3:0]        first_idx;
  logic [2:0]        state_q;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_stream_ctrl #(
    .DATA_W   (DATA_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .system_clk (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .len        (len),
    .det_z      (det_z),
    .det_x      (det_x),
    .det_step   (det_step),
    .det_clr    (det_clr),
    .busy       (busy),
    .done       (done),
    .match_cnt  (match_cnt),
    .first_idx  (first_idx),
    .state_q    (state_q)
  );

  // Sequence detector for 1,0,1,0,1,1 (first bit oldest), overlapping, registered z.
  logic [5:0] det_hist;
  always @(posedge clk) begin
    if (reset || det_clr) begin
      det_hist <= '0;
      det_z    <= 1'b0;
    end else if (det_step) begin
      det_hist <= {det_hist[4:0], det_x};
      det_z    <= ({det_hist[4:0], det_x} == 6'b101011);
    end
  end

  // Expected result of a run: hits among the first L bits, sent LSB first.
  function automatic void calc(input logic [15:0] d, input int L, output int c, output int f);
    logic [5:0] w;
    w = '0;
    c = 0;
    f = 15;
    for (int i = 0; i < L; i++) begin
      w = {w[4:0], d[i]};
      if (w == 6'b101011) begin
        c++;
        if (f == 15) f = i;
      end
    end
  endfunction

  // Run scoreboard, advanced on every rising edge.
  int          cyc = 0;
  bit          m_known = 0;
  bit          m_run = 0;
  bit          m_fin = 0;
  int          m_e0 = 0;
  int          m_L = 0;
  int          m_end = 1;
  logic [15:0] m_data = '0;
  int          m_cnt = 0;
  int          m_first = 15;
  int          m_ncnt = 0;
  int          m_nfirst = 15;
  logic        m_x = 1'b0;

  always @(posedge clk) begin
    cyc++;
    m_fin = 0;
    if (reset) begin
      m_known = 1;
      m_run   = 0;
      m_cnt   = 0;
      m_first = 15;
      m_x     = 1'b0;
    end else if (m_known) begin
      if (m_run && (cyc == m_e0 + m_end)) begin
        m_run   = 0;
        m_fin   = 1;
        m_cnt   = m_ncnt;
        m_first = m_nfirst;
        if (m_L > 0) m_x = m_data[m_L-1];
      end else if (m_run && (cyc == m_e0 + 1)) begin
        m_data = data_in;
        m_L    = (len > 5'd16) ? 16 : int'(len);
        m_end  = 2 + m_L * P;
        calc(m_data, m_L, m_ncnt, m_nfirst);
      end else if (!m_run && start) begin
        m_run = 1;
        m_e0  = cyc;
        m_L   = (len > 5'd16) ? 16 : int'(len);
        m_end = (m_L == 0) ? 1 : 2 + m_L * P;
        if (m_L == 0) begin
          m_ncnt   = 0;
          m_nfirst = 15;
        end
      end
    end
  end

  // Hand-computed expectations for the current directed run.
  bit lit_on = 0;
  int lit_cnt = 0;
  int lit_first = 15;
  int lit_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  int       t, j, k, ph;
  int       seen_done = 0;
  int       n_step = 0;
  int       n_clr = 0;
  logic [2:0] e_state;
  logic     e_busy, e_step, e_clr, e_done, e_x;

  always @(negedge clk) begin
    if (m_known) begin
      e_state = 3'd0;
      e_busy  = 1'b0;
      e_step  = 1'b0;
      e_clr   = 1'b0;
      e_done  = 1'b0;
      e_x     = m_x;
      if (m_run) begin
        t = cyc - m_e0 + 1;
        if (t == 1) begin
          seen_done = 0;
          n_step    = 0;
          n_clr     = 0;
        end
        if (det_step === 1'b1) n_step++;
        if (det_clr === 1'b1) n_clr++;
        if ((done === 1'b1) && (seen_done == 0)) seen_done = t;
        if (t == m_end) begin
          e_state = 3'd4;
          e_done  = 1'b1;
          if (m_L > 0) e_x = m_data[m_L-1];
          chk("match_cnt_done", match_cnt, m_ncnt);
          chk("first_idx_done", first_idx, m_nfirst);
        end else if (t == 1) begin
          e_state = 3'd1;
          e_busy  = 1'b1;
          e_clr   = 1'b1;
          chk("match_cnt_hold", match_cnt, m_cnt);
          chk("first_idx_hold", first_idx, m_first);
        end else begin
          j      = t - 2;
          k      = j / P;
          ph     = j % P;
          e_busy = 1'b1;
          e_x    = m_data[k];
          if (ph < P - 1) begin
            e_state = 3'd2;
            e_step  = (ph == P - 2);
          end else begin
            e_state = 3'd3;
          end
        end
      end else begin
        chk("match_cnt_idle", match_cnt, m_cnt);
        chk("first_idx_idle", first_idx, m_first);
      end
      chk("state_q", state_q, e_state);
      chk("busy", busy, e_busy);
      chk("det_step", det_step, e_step);
      chk("det_clr", det_clr, e_clr);
      chk("done", done, e_done);
      chk("det_x", det_x, e_x);
      if (m_fin) begin
        chk("step_pulses", n_step, m_L);
        chk("clr_pulses", n_clr, (m_L > 0) ? 1 : 0);
        if (lit_on) begin
          chk("done_cycle", seen_done, lit_done);
          chk("lit_match_cnt", match_cnt, lit_cnt);
          chk("lit_first_idx", first_idx, lit_first);
          chk("model_cnt", m_cnt, lit_cnt);
          chk("model_first", m_first, lit_first);
        end
      end
    end
  end

  // Starts a run; inputs are scrambled once LOAD has latched them.
  task automatic run(input logic [15:0] d, input logic [4:0] l, input int lc, input int lf,
                     input int ld, input bit restart_mid);
    int lcl, endt;
    lcl       = (l > 5'd16) ? 16 : int'(l);
    endt      = (lcl == 0) ? 1 : 2 + lcl * P;
    lit_on    = 1;
    lit_cnt   = lc;
    lit_first = lf;
    lit_done  = ld;
    data_in   = d;
    len       = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    data_in = ~d;
    len     = 5'd3;
    if (restart_mid) begin
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
    end
    repeat (endt + 2) @(posedge clk);
    #1;
  endtask

  // Starts a run and hits reset during its third SAMPLE cycle.
  task automatic reset_mid(input logic [15:0] d, input logic [4:0] l);
    int t3;
    t3      = 1 + 3 * P;
    lit_on  = 0;
    data_in = d;
    len     = l;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (t3 - 1) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run(16'h0035, 5'd6,  1, 5,  D6,  1'b0);
    run(16'h0D75, 5'd12, 2, 5,  D12, 1'b0);
    run(16'h1234, 5'd0,  0, 15, 1,   1'b0);
    run(16'h0035, 5'd6,  1, 5,  D6,  1'b1);
    run(16'hAD75, 5'd20, 2, 5,  D16, 1'b0);
    run(16'hFFFF, 5'd16, 0, 15, D16, 1'b0);
    reset_mid(16'h0035, 5'd6);
    run(16'h0035, 5'd6,  1, 5,  D6,  1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
